imem_axi_fetch_master: RTL and testbench
========================================

# imem_axi_fetch_master

Instruction-fetch bus master between the CPU fetch stage and the instruction-memory AXI4-Lite slave. Turns single-word fetch requests (PC) into AXI4-Lite read transactions and returns the instruction word with an error flag. Handles branch-redirect flushes without breaking AXI handshake rules, and rejects misaligned PCs locally. Read-only; one transaction outstanding.

## Interface
- ADDR_W, 32, fetch/AXI address width
- DATA_W, 32, instruction/AXI data width (fixed 32; other values unsupported)
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req_valid  in  1  core fetch request valid
- if_req_ready  out  1  request accepted when valid&ready
- if_req_addr  in  ADDR_W  fetch PC
- if_flush  in  1  single-cycle pulse: discard any in-flight/pending fetch
- if_rsp_valid  out  1  instruction available
- if_rsp_ready  in  1  core consumes response
- if_rsp_data  out  DATA_W  instruction word (0 on error)
- if_rsp_err  out  1  1 = bus error or misaligned PC
- if_rsp_addr  out  ADDR_W  PC of returned word
- M_AXI_ARADDR  out  ADDR_W  read address
- M_AXI_ARPROT  out  3  constant 3'b100 (instruction, secure, unprivileged)
- M_AXI_ARVALID  out  1  read address valid
- M_AXI_ARREADY  in  1  slave address accept
- M_AXI_RDATA  in  DATA_W  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RVALID  in  1  read data valid
- M_AXI_RREADY  out  1  master data accept

## Operation
- States: IDLE, ADDR, DATA, RSP, DRAIN.
- IDLE: if_req_ready = 1 when !if_flush. On accept: latch PC. If PC[1:0] != 0 -> RSP with err=1, data=0, no AXI traffic. Else -> ADDR.
- ADDR: ARVALID=1, ARADDR=latched PC, held stable until ARREADY. On handshake -> DATA, or -> DRAIN if flush seen during ADDR or this cycle (ARVALID never dropped early on flush).
- DATA: RREADY=1. On RVALID: capture RDATA; err = (RRESP != 2'b00) -> RSP. Flush without RVALID -> DRAIN. Flush with RVALID same cycle -> beat dropped, IDLE.
- DRAIN: RREADY=1, outputs to core silent; on RVALID -> IDLE, beat dropped.
- RSP: if_rsp_valid=1, data/err/addr stable until if_rsp_ready. Handshake -> IDLE. Flush -> drop response, IDLE (flush wins over simultaneous rsp_ready; response not counted as delivered).
- Flush in IDLE: no effect, request that cycle not accepted.
- Pending-flush flag set by flush in ADDR, cleared on leaving DRAIN.

## Timing
- Reset: state IDLE, ARVALID=0, RREADY=0, ARADDR=0, if_rsp_valid=0, if_rsp_data=0, if_rsp_err=0, if_rsp_addr=0, flush flag=0. if_req_ready=1 after reset (combinational from state). Reset mid-transaction abandons it; slave shares rst_n.
- All AXI and if_rsp outputs registered except if_req_ready.
- Request accepted at edge N -> ARVALID high cycle N+1. AR handshake at edge M -> RREADY high M+1. R handshake at edge K -> if_rsp_valid high K+1.
- Minimum latency with zero-wait slave: accept to if_rsp_valid = 3 cycles; next request accepted the cycle after rsp handshake (IDLE).
- Misaligned: accept to if_rsp_valid = 1 cycle.
- No AXI combinational paths input->output.

## Structure
- Package imem_fetch_pkg: state encoding (3-bit localparams), RESP_OKAY=2'b00, RESP_SLVERR=2'b10, IFETCH_ARPROT=3'b100.
- Single flat module; no sub-module. Shares package response codes with the instruction-memory slave.

## Test plan
- Aligned fetch 0x0000_0010, slave returns 0x0000_0013 OKAY -> ARADDR=0x10, ARPROT=3'b100, if_rsp_data=0x13, err=0, addr=0x10, 3-cycle latency with zero-wait slave.
- Misaligned fetch 0x0000_0006 -> no ARVALID ever, if_rsp_valid next cycle, err=1, data=0, addr=0x6.
- Slave returns RRESP=2'b10 for 0x0000_0100 -> if_rsp_err=1, if_rsp_data=0.
- Flush while ARVALID held with ARREADY stalled 5 cycles -> ARVALID stays high until ARREADY, R beat dropped, no if_rsp_valid; following fetch 0x20 returns its own data.
- Response held with if_rsp_ready=0 for 4 cycles -> data/err/addr stable; flush in cycle 3 -> if_rsp_valid falls next cycle, returns to IDLE.
- Assert rst_n=0 in DATA state -> all outputs reset values immediately; after release, fetch 0x0 completes normally.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// ---------------------------------------------------------------------------
// imem_fetch_pkg
//
// Shared definitions for the instruction-fetch path:
//   - FSM state encoding of the fetch master (3-bit codes plus an enum view)
//   - AXI4-Lite read response codes, shared with the instruction-memory slave
//   - ARPROT value used for every instruction fetch
//   - small helper to classify a fetch PC as misaligned
// ---------------------------------------------------------------------------
package imem_fetch_pkg;

    // Raw state codes, kept as plain localparams so that other blocks and
    // checkers can decode the state without depending on the enum type.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_RSP   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ADDR  = ST_ADDR,
        S_DATA  = ST_DATA,
        S_RSP   = ST_RSP,
        S_DRAIN = ST_DRAIN
    } fetch_state_t;

    // AXI4-Lite read response codes.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Instruction access, secure, unprivileged.
    localparam logic [2:0] IFETCH_ARPROT = 3'b100;

    // Instructions are 32-bit words; any PC with non-zero low bits is rejected.
    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/imem_axi_fetch_master.sv
// ---------------------------------------------------------------------------
// imem_axi_fetch_master
//
// Bus master between the CPU fetch stage and the instruction-memory AXI4-Lite
// slave. Each accepted fetch request (a PC) becomes a single AXI4-Lite read;
// the returned word is handed back to the core together with an error flag.
// One transaction is outstanding at a time and the master never writes.
//
// Handshake rule used on every channel: a transfer happens on the rising edge
// where valid and ready are both high; once valid is raised it stays high, with
// its payload stable, until that transfer happens. A flush from the core never
// withdraws ARVALID; the in-flight read is completed on AXI and its beat is
// discarded instead.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   if_req_valid/ready fetch request handshake, if_req_addr = PC
//   if_flush           one-cycle pulse, drops any pending/in-flight fetch
//   if_rsp_valid/ready fetch response handshake
//   if_rsp_data        instruction word (0 when if_rsp_err is set)
//   if_rsp_err         bus error or misaligned PC
//   if_rsp_addr        PC of the returned word
//   M_AXI_AR*          AXI4-Lite read address channel (master side)
//   M_AXI_R*           AXI4-Lite read data channel (master side)
//
// All AXI and response outputs come straight from flops; only if_req_ready is
// decoded combinationally from the state and if_flush.
// ---------------------------------------------------------------------------
module imem_axi_fetch_master
    import imem_fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    // Core fetch request
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    input  logic              if_flush,

    // Core fetch response
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    output logic [ADDR_W-1:0] if_rsp_addr,

    // AXI4-Lite read address channel
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [2:0]        M_AXI_ARPROT,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,

    // AXI4-Lite read data channel
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    fetch_state_t      state;

    // Registered outputs
    logic              arvalid_q;
    logic [ADDR_W-1:0] araddr_q;   // also serves as the latched PC of the fetch
    logic              rready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic [ADDR_W-1:0] rsp_addr_q;

    // Remembers a flush seen while the address phase was still open, so the
    // read can be steered into DRAIN once the slave finally takes the address.
    logic              flush_pend_q;

    // Requests are only taken in IDLE; a flush in the same cycle blocks the
    // accept so a redirect never races with the stale PC.
    assign if_req_ready = (state == S_IDLE) && !if_flush;

    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = IFETCH_ARPROT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

    assign if_rsp_valid = rsp_valid_q;
    assign if_rsp_data  = rsp_data_q;
    assign if_rsp_err   = rsp_err_q;
    assign if_rsp_addr  = rsp_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            rready_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            rsp_addr_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (if_req_valid && !if_flush) begin
                        if (is_misaligned(if_req_addr[1:0])) begin
                            // Rejected locally: answer next cycle, no bus access.
                            state       <= S_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b1;
                            rsp_addr_q  <= if_req_addr;
                        end else begin
                            state     <= S_ADDR;
                            arvalid_q <= 1'b1;
                            araddr_q  <= if_req_addr;
                        end
                    end
                end

                S_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        if (flush_pend_q || if_flush) begin
                            // Fetch was cancelled while the address was waiting;
                            // the read must still be drained on AXI.
                            state        <= S_DRAIN;
                            flush_pend_q <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end else if (if_flush) begin
                        flush_pend_q <= 1'b1;
                    end
                end

                S_DATA: begin
                    if (M_AXI_RVALID) begin
                        rready_q <= 1'b0;
                        if (if_flush) begin
                            // Beat consumed this edge but belongs to a dead fetch.
                            state <= S_IDLE;
                        end else begin
                            state       <= S_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= (M_AXI_RRESP != RESP_OKAY);
                            rsp_data_q  <= (M_AXI_RRESP == RESP_OKAY) ? M_AXI_RDATA : '0;
                            rsp_addr_q  <= araddr_q;
                        end
                    end else if (if_flush) begin
                        state <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    // RREADY stays high; the beat is accepted and thrown away.
                    if (M_AXI_RVALID) begin
                        rready_q     <= 1'b0;
                        flush_pend_q <= 1'b0;
                        state        <= S_IDLE;
                    end
                end

                S_RSP: begin
                    // A flush takes priority over a simultaneous rsp_ready: the
                    // word is withdrawn, not delivered.
                    if (if_flush || if_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    arvalid_q    <= 1'b0;
                    rready_q     <= 1'b0;
                    rsp_valid_q  <= 1'b0;
                    flush_pend_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_axi_fetch_master.sv
// ---------------------------------------------------------------------------
// tb_imem_axi_fetch_master
//
// Bench for imem_axi_fetch_master. A behavioural AXI4-Lite slave returns
// (address + 3) as the instruction word and SLVERR for err_addr; its address
// and read latencies are adjustable. Expected core responses and expected
// AR addresses are queued when requests are driven and popped by monitors.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_axi_fetch_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int W      = ADDR_W + DATA_W + 1;   // {addr, data, err}
    localparam int OW     = 101;                   // packed output snapshot

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_flush;
    logic              if_rsp_valid;
    logic              if_rsp_ready;
    logic [DATA_W-1:0] if_rsp_data;
    logic              if_rsp_err;
    logic [ADDR_W-1:0] if_rsp_addr;
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic [2:0]        M_AXI_ARPROT;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [DATA_W-1:0] M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    imem_axi_fetch_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_req_addr   (if_req_addr),
        .if_flush      (if_flush),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_ready  (if_rsp_ready),
        .if_rsp_data   (if_rsp_data),
        .if_rsp_err    (if_rsp_err),
        .if_rsp_addr   (if_rsp_addr),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0]      exp_q[$];
    logic [ADDR_W-1:0] ar_q[$];

    // slave configuration
    int                ar_stall = 0;
    int                r_delay  = 0;
    logic [ADDR_W-1:0] err_addr = 32'h0000_0100;

    // Reference model of the response the core must see for a PC.
    function automatic logic [W-1:0] model_rsp(input logic [ADDR_W-1:0] a);
        if (a[1:0] != 2'b00) return {a, {DATA_W{1'b0}}, 1'b1};
        if (a == err_addr)   return {a, {DATA_W{1'b0}}, 1'b1};
        return {a, a + 32'h3, 1'b0};
    endfunction

    // ---------------- AXI4-Lite slave model ----------------
    initial begin : slave_model
        logic              ar_hs, ar_wait, r_hs, r_pend;
        logic [ADDR_W-1:0] s_addr, r_addr;
        int                st_cnt, r_wait;
        ar_hs = 1'b0; ar_wait = 1'b0; r_hs = 1'b0; r_pend = 1'b0;
        s_addr = '0; r_addr = '0; st_cnt = 0; r_wait = 0;
        M_AXI_ARREADY = 1'b1;
        M_AXI_RVALID  = 1'b0;
        M_AXI_RDATA   = '0;
        M_AXI_RRESP   = 2'b00;
        forever begin
            @(negedge clk);
            ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
            ar_wait = M_AXI_ARVALID && !M_AXI_ARREADY;
            r_hs    = M_AXI_RVALID && M_AXI_RREADY;
            s_addr  = M_AXI_ARADDR;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                M_AXI_ARREADY = (ar_stall == 0);
                M_AXI_RVALID  = 1'b0;
                r_pend = 1'b0;
                st_cnt = 0;
            end else begin
                if (r_hs) M_AXI_RVALID = 1'b0;
                if (ar_hs) begin
                    r_pend = 1'b1;
                    r_wait = r_delay;
                    r_addr = s_addr;
                    st_cnt = 0;
                    M_AXI_ARREADY = (ar_stall == 0);
                end else if (ar_wait) begin
                    st_cnt++;
                    if (st_cnt >= ar_stall) M_AXI_ARREADY = 1'b1;
                end else begin
                    M_AXI_ARREADY = (ar_stall == 0);
                end
                if (r_pend && !M_AXI_RVALID) begin
                    if (r_wait == 0) begin
                        M_AXI_RVALID = 1'b1;
                        M_AXI_RDATA  = r_addr + 32'h3;
                        M_AXI_RRESP  = (r_addr == err_addr) ? 2'b10 : 2'b00;
                        r_pend = 1'b0;
                    end else begin
                        r_wait--;
                    end
                end
            end
        end
    end

    // ---------------- AR channel monitor ----------------
    initial begin : ar_monitor
        logic              pend_prev;
        logic [ADDR_W-1:0] addr_prev, exp_a;
        pend_prev = 1'b0; addr_prev = '0; exp_a = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_prev = 1'b0;
            end else begin
                if (pend_prev) begin
                    n_cmp++;
                    if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== addr_prev) begin
                        n_err++;
                        $display("FAIL ar_stable: valid=%b addr=%h, required valid=1 addr=%h",
                                 M_AXI_ARVALID, M_AXI_ARADDR, addr_prev);
                    end
                end
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                    n_cmp++;
                    if (ar_q.size() == 0) begin
                        n_err++;
                        $display("FAIL ar_unexpected: addr=%h, required no read", M_AXI_ARADDR);
                    end else begin
                        exp_a = ar_q.pop_front();
                        if ({M_AXI_ARADDR, M_AXI_ARPROT} !== {exp_a, 3'b100}) begin
                            n_err++;
                            $display("FAIL ar_addr: addr=%h prot=%b, required addr=%h prot=100",
                                     M_AXI_ARADDR, M_AXI_ARPROT, exp_a);
                        end
                    end
                end
                pend_prev = M_AXI_ARVALID && !M_AXI_ARREADY;
                addr_prev = M_AXI_ARADDR;
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin : rsp_monitor
        logic [W-1:0] exp_r;
        exp_r = '0;
        forever begin
            @(negedge clk);
            if (rst_n && if_rsp_valid && if_rsp_ready && !if_flush) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_unexpected: addr=%h data=%h err=%b, required none",
                             if_rsp_addr, if_rsp_data, if_rsp_err);
                end else begin
                    exp_r = exp_q.pop_front();
                    if ({if_rsp_addr, if_rsp_data, if_rsp_err} !== exp_r) begin
                        n_err++;
                        $display("FAIL rsp_data: addr=%h data=%h err=%b, required addr=%h data=%h err=%b",
                                 if_rsp_addr, if_rsp_data, if_rsp_err,
                                 exp_r[W-1 -: ADDR_W], exp_r[DATA_W:1], exp_r[0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic [ADDR_W-1:0] a, input bit keep);
        int n;
        @(posedge clk);
        #1;
        if (a[1:0] == 2'b00) ar_q.push_back(a);
        if (keep) exp_q.push_back(model_rsp(a));
        if_req_addr  = a;
        if_req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!if_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!if_req_ready) begin
            n_err++;
            $display("FAIL req_accept: addr=%h ready=%b after %0d cycles, required 1", a, if_req_ready, n);
        end
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
    endtask

    task automatic wait_rsp_valid(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!if_rsp_valid && cyc < limit);
        n_cmp++;
        if (!if_rsp_valid) begin
            n_err++;
            $display("FAIL rsp_timeout: valid=%b after %0d cycles, required 1", if_rsp_valid, cyc);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && ar_q.size() == 0 && if_req_ready && !if_rsp_valid) && n < limit) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || ar_q.size() != 0 || !if_req_ready) begin
            n_err++;
            $display("FAIL idle_timeout: rsp_left=%0d ar_left=%0d ready=%b, required 0/0/1",
                     exp_q.size(), ar_q.size(), if_req_ready);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [OW-1:0] act;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        act = {M_AXI_ARVALID, M_AXI_RREADY, M_AXI_ARADDR, if_rsp_valid, if_rsp_err,
               if_rsp_data, if_rsp_addr, if_req_ready};
        n_cmp++;
        if (act !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: outputs=%h, required all zero with req_ready=1", act);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (if_req_ready !== 1'b1 || M_AXI_ARVALID !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset: req_ready=%b arvalid=%b, required 1/0", if_req_ready, M_AXI_ARVALID);
        end
    endtask

    task automatic test_aligned();
        int cyc;
        ar_stall = 0;
        r_delay  = 0;
        send_req(32'h0000_0010, 1'b1);
        wait_rsp_valid(20, cyc);
        n_cmp++;
        if (cyc !== 3) begin
            n_err++;
            $display("FAIL aligned_latency: %0d cycles, required 3", cyc);
        end
        wait_idle(20);
    endtask

    task automatic test_misaligned();
        int   cyc;
        logic saw_ar;
        saw_ar = 1'b0;
        send_req(32'h0000_0006, 1'b1);
        if (M_AXI_ARVALID) saw_ar = 1'b1;
        wait_rsp_valid(10, cyc);
        n_cmp++;
        if (cyc !== 1) begin
            n_err++;
            $display("FAIL misaligned_latency: %0d cycles, required 1", cyc);
        end
        repeat (5) begin
            @(negedge clk);
            if (M_AXI_ARVALID) saw_ar = 1'b1;
        end
        n_cmp++;
        if (saw_ar !== 1'b0) begin
            n_err++;
            $display("FAIL misaligned_no_axi: arvalid seen=%b, required 0", saw_ar);
        end
        wait_idle(20);
    endtask

    task automatic test_slverr();
        int cyc;
        send_req(err_addr, 1'b1);
        wait_rsp_valid(20, cyc);
        wait_idle(20);
    endtask

    task automatic test_flush_addr();
        int   cyc;
        logic saw_rsp;
        ar_stall = 5;
        saw_rsp  = 1'b0;
        send_req(32'h0000_0040, 1'b0);
        @(posedge clk);
        #1;
        if_flush = 1'b1;
        @(posedge clk);
        #1;
        if_flush = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (if_rsp_valid) saw_rsp = 1'b1;
        end
        n_cmp++;
        if (saw_rsp !== 1'b0 || ar_q.size() != 0) begin
            n_err++;
            $display("FAIL flush_addr: rsp_valid seen=%b ar_left=%0d, required 0/0", saw_rsp, ar_q.size());
        end
        ar_stall = 0;
        send_req(32'h0000_0020, 1'b1);
        wait_rsp_valid(20, cyc);
        wait_idle(20);
    endtask

    task automatic test_rsp_hold();
        int           cyc;
        logic [W-1:0] snap;
        if_rsp_ready = 1'b0;
        send_req(32'h0000_0030, 1'b0);
        wait_rsp_valid(20, cyc);
        snap = {if_rsp_addr, if_rsp_data, if_rsp_err};
        n_cmp++;
        if (snap !== model_rsp(32'h0000_0030)) begin
            n_err++;
            $display("FAIL hold_value: got %h, required %h", snap, model_rsp(32'h0000_0030));
        end
        @(negedge clk);
        n_cmp++;
        if ({if_rsp_valid, if_rsp_addr, if_rsp_data, if_rsp_err} !== {1'b1, snap}) begin
            n_err++;
            $display("FAIL hold_stable_2: valid=%b value=%h, required 1 %h", if_rsp_valid,
                     {if_rsp_addr, if_rsp_data, if_rsp_err}, snap);
        end
        @(posedge clk);
        #1;
        if_flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({if_rsp_valid, if_rsp_addr, if_rsp_data, if_rsp_err} !== {1'b1, snap}) begin
            n_err++;
            $display("FAIL hold_stable_3: valid=%b value=%h, required 1 %h", if_rsp_valid,
                     {if_rsp_addr, if_rsp_data, if_rsp_err}, snap);
        end
        @(posedge clk);
        #1;
        if_flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (if_rsp_valid !== 1'b0 || if_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL hold_flush: rsp_valid=%b req_ready=%b, required 0/1", if_rsp_valid, if_req_ready);
        end
        if_rsp_ready = 1'b1;
        wait_idle(20);
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 10; i++) begin
            ar_stall = int'($urandom_range(0, 3));
            r_delay  = int'($urandom_range(0, 3));
            a = ADDR_W'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (i == 3) a = err_addr;
            send_req(a, 1'b1);
        end
        wait_idle(200);
        ar_stall = 0;
        r_delay  = 0;
    endtask

    task automatic test_reset_mid();
        int            n;
        int            cyc;
        logic [OW-1:0] act;
        ar_stall = 0;
        r_delay  = 6;
        send_req(32'h0000_0050, 1'b0);
        n = 0;
        @(negedge clk);
        while (!M_AXI_RREADY && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (M_AXI_RREADY !== 1'b1) begin
            n_err++;
            $display("FAIL reach_data: rready=%b, required 1", M_AXI_RREADY);
        end
        #2;
        rst_n = 1'b0;
        #1;
        act = {M_AXI_ARVALID, M_AXI_RREADY, M_AXI_ARADDR, if_rsp_valid, if_rsp_err,
               if_rsp_data, if_rsp_addr, if_req_ready};
        n_cmp++;
        if (act !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_mid: outputs=%h, required all zero with req_ready=1", act);
        end
        r_delay = 0;
        ar_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_req(32'h0000_0000, 1'b1);
        wait_rsp_valid(20, cyc);
        wait_idle(20);
    endtask

    // ---------------- sequence ----------------
    initial begin
        if_req_valid = 1'b0;
        if_req_addr  = '0;
        if_flush     = 1'b0;
        if_rsp_ready = 1'b1;

        test_reset();
        test_aligned();
        test_misaligned();
        test_slverr();
        test_flush_addr();
        test_rsp_hold();
        test_back_to_back();
        test_reset_mid();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
